// File: rtl/ram_access_ctrl_if.sv
// Bus bundle for ram_access_ctrl: control, two read requesters, write port and RAM ports.
// Handshake: a transfer happens on a rising edge where valid and ready are both high.
// ready may depend on valid in the same cycle, but valid never depends on ready.
interface ram_access_ctrl_if #(
    parameter int address_width = 8,
    parameter int data_width    = 16
);
    logic                     clear_req;
    logic                     init_done;
    logic                     req_valid_0;
    logic                     req_valid_1;
    logic [address_width-1:0] req_addr_0;
    logic [address_width-1:0] req_addr_1;
    logic                     req_ready_0;
    logic                     req_ready_1;
    logic                     rsp_valid;
    logic                     rsp_id;
    logic [data_width-1:0]    rsp_data;
    logic                     wr_valid;
    logic [address_width-1:0] wr_addr;
    logic [data_width-1:0]    wr_data;
    logic                     wr_ready;
    logic                     ram_read_enable;
    logic [address_width-1:0] ram_read_address;
    logic [data_width-1:0]    ram_data_out;
    logic                     ram_write_enable;
    logic [address_width-1:0] ram_write_address;
    logic [data_width-1:0]    ram_data_in;

    modport slave (
        input  clear_req, req_valid_0, req_valid_1, req_addr_0, req_addr_1,
               wr_valid, wr_addr, wr_data, ram_data_out,
        output init_done, req_ready_0, req_ready_1, rsp_valid, rsp_id, rsp_data,
               wr_ready, ram_read_enable, ram_read_address,
               ram_write_enable, ram_write_address, ram_data_in
    );

    modport master (
        output clear_req, req_valid_0, req_valid_1, req_addr_0, req_addr_1,
               wr_valid, wr_addr, wr_data, ram_data_out,
        input  init_done, req_ready_0, req_ready_1, rsp_valid, rsp_id, rsp_data,
               wr_ready, ram_read_enable, ram_read_address,
               ram_write_enable, ram_write_address, ram_data_in
    );
endinterface

// File: rtl/ram_access_ctrl.sv
// RAM clear-then-serve controller: zeroes the RAM, then arbitrates two readers and one writer.
// Define RAM_ARB_ROUND_ROBIN_EN for round-robin read arbitration; otherwise requester 0 has fixed priority.
module ram_access_ctrl #(
    parameter int address_width = 8,
    parameter int data_width    = 16
) (
    input  logic              clk,
    input  logic              rst,
    ram_access_ctrl_if.slave  bus,
    output logic              dbg_state_o
);
    typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

    localparam logic [address_width-1:0] LAST_ADDR  = '1;
    localparam logic [address_width-1:0] ADDR_ONE   = {{(address_width-1){1'b0}}, 1'b1};
    localparam logic [data_width-1:0]    CLEAR_WORD = '0;

    state_t                   state_q, state_d;
    logic [address_width-1:0] clr_cnt_q, clr_cnt_d;
    logic [address_width-1:0] rd_addr_q, rd_addr_d;
    logic                     rsp_valid_q, rsp_valid_d;
    logic                     rsp_id_q, rsp_id_d;
    logic                     active;
    logic                     prefer_1;
    logic                     gnt_0, gnt_1, gnt_any;

`ifdef RAM_ARB_ROUND_ROBIN_EN
    // Holds the requester that wins the next contended cycle.
    logic pref_q, pref_d;

    assign prefer_1 = pref_q;
    assign pref_d   = gnt_any ? gnt_0 : pref_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pref_q <= 1'b0;
        end else begin
            pref_q <= pref_d;
        end
    end
`else
    assign prefer_1 = 1'b0;
`endif

    assign active  = (state_q == ST_RUN) && !bus.clear_req;
    assign gnt_0   = active && bus.req_valid_0 && (!bus.req_valid_1 || !prefer_1);
    assign gnt_1   = active && bus.req_valid_1 && (!bus.req_valid_0 || prefer_1);
    assign gnt_any = gnt_0 || gnt_1;

    always_comb begin
        state_d               = state_q;
        clr_cnt_d             = clr_cnt_q;
        rd_addr_d             = rd_addr_q;
        rsp_valid_d           = gnt_any;
        rsp_id_d              = rsp_id_q;
        bus.ram_write_enable  = 1'b0;
        bus.ram_write_address = bus.wr_addr;
        bus.ram_data_in       = bus.wr_data;

        if (gnt_any) begin
            rsp_id_d  = gnt_1;
            rd_addr_d = gnt_1 ? bus.req_addr_1 : bus.req_addr_0;
        end

        case (state_q)
            ST_INIT: begin
                bus.ram_write_enable  = 1'b1;
                bus.ram_write_address = clr_cnt_q;
                bus.ram_data_in       = CLEAR_WORD;
                clr_cnt_d             = clr_cnt_q + ADDR_ONE;
                if (clr_cnt_q == LAST_ADDR) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (bus.clear_req) begin
                    state_d   = ST_INIT;
                    clr_cnt_d = '0;
                end else begin
                    bus.ram_write_enable = bus.wr_valid;
                end
            end
            default: begin
                state_d   = ST_INIT;
                clr_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_INIT;
            clr_cnt_q   <= '0;
            rd_addr_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            rd_addr_q   <= rd_addr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
        end
    end

    // The RAM latches ram_read_address on the edge, so rsp_data is simply its output.
    assign bus.ram_read_enable  = gnt_any;
    assign bus.ram_read_address = rd_addr_d;
    assign bus.req_ready_0      = gnt_0;
    assign bus.req_ready_1      = gnt_1;
    assign bus.wr_ready         = active;
    assign bus.init_done        = (state_q == ST_RUN);
    assign bus.rsp_valid        = rsp_valid_q;
    assign bus.rsp_id           = rsp_id_q;
    assign bus.rsp_data         = bus.ram_data_out;
    assign dbg_state_o          = state_q;
endmodule
